// File: rtl/fib_sweep_host.sv
// Sweeps n_first..n_last through the Fibonacci request/done handshake and
// queues (n, result) pairs in a small FIFO. FIB_TIMEOUT_EN adds a per-request watchdog.
module fib_sweep_host #(
  parameter int MAX_N       = 24,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  n_first,
  input  logic [4:0]  n_last,
  output logic        busy,
  output logic        sweep_done,
  output logic        cfg_err,
  output logic [4:0]  fib_n,
  output logic        fib_go,
  input  logic        fib_done,
  input  logic [16:0] fib_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_n,
  output logic [16:0] res_data,
  output logic        timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0]  MAX_N5 = 5'(MAX_N);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, STALL, FINISH} state_t;
  state_t state, state_nxt;

  logic [4:0]    cur, cur_nxt, last, last_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [4:0]    mem_n [DEPTH];
  logic [16:0]   mem_d [DEPTH];
  logic          push, pop, full, cfg_ok, accept, cfg_bad, to_hit;

  assign full   = (count == FULL);
  assign pop    = res_valid & res_ready;
  assign cfg_ok = (n_first <= n_last) && (n_last <= MAX_N5);
  assign fib_n  = cur;
  assign res_n    = mem_n[rd_ptr];
  assign res_data = mem_d[rd_ptr];

`ifdef FIB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  // Counts cycles spent in the current ISSUE; zero everywhere else.
  always_ff @(posedge clk) begin
    if (reset || state != ISSUE) tcnt <= '0;
    else                         tcnt <= tcnt + 1'b1;
  end
  assign to_hit = (state == ISSUE) && !fib_done && (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    last_nxt  = last;
    push      = 1'b0;
    accept    = 1'b0;
    cfg_bad   = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (cfg_ok) begin
          accept    = 1'b1;
          cur_nxt   = n_first;
          last_nxt  = n_last;
          state_nxt = full ? STALL : ISSUE;
        end else begin
          cfg_bad = 1'b1;
        end
      end
      ISSUE: if (fib_done) begin
        push = 1'b1;
        if (cur == last) state_nxt = FINISH;
        else begin
          cur_nxt   = cur + 5'd1;
          state_nxt = GAP;
        end
      end else if (to_hit) begin
        state_nxt = IDLE;
      end
      GAP:    state_nxt = full ? STALL : ISSUE;
      STALL:  if (!full) state_nxt = ISSUE;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // Outputs are flops loaded from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      last        <= '0;
      fib_go      <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last       <= last_nxt;
      fib_go     <= (state_nxt == ISSUE);
      busy       <= (state_nxt == ISSUE) || (state_nxt == GAP) || (state_nxt == STALL);
      sweep_done <= (state_nxt == FINISH);
      cfg_err    <= cfg_bad;
      if (to_hit)      timeout_err <= 1'b1;
      else if (accept) timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      res_valid <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_n[wr_ptr] <= cur;
      mem_d[wr_ptr] <= fib_data;
    end
  end
endmodule

// File: tb/tb_fib_sweep_host.sv
// Bench for fib_sweep_host: scripted and randomized sweeps against a
// list-based model of the expected requests and FIFO entries.
module tb_fib_sweep_host;
  logic        clk = 1'b0;
  logic        reset, start, busy, sweep_done, cfg_err, fib_go, res_valid, timeout_err;
  logic        res_ready = 1'b1;
  logic        fib_done = 1'b0;
  logic [4:0]  n_first, n_last, fib_n, res_n;
  logic [16:0] fib_data = '0;
  logic [16:0] res_data;

  fib_sweep_host dut (
    .clk(clk), .reset(reset), .start(start), .n_first(n_first), .n_last(n_last),
    .busy(busy), .sweep_done(sweep_done), .cfg_err(cfg_err), .fib_n(fib_n),
    .fib_go(fib_go), .fib_done(fib_done), .fib_data(fib_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n),
    .res_data(res_data), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  logic [16:0] rdata [32];
  bit never_done = 0, gap_inject = 0, rand_dly = 0, rand_ready = 0;
  logic [4:0]  req_q [$];
  logic [21:0] got_q [$];
  int done_cnt = 0, cfg_cnt = 0, go_hi_cnt = 0;
  logic busy_at_done = 1'b1;

  // Responder: answers each request after a delay; can inject a done in the first idle cycle.
  int r_cnt = 0, r_dly = 3;
  bit r_sent = 0, r_go_was = 0;
  always @(negedge clk) begin
    if (!fib_go) begin
      r_cnt = 0; r_sent = 0; fib_done = 1'b0;
      if (gap_inject && r_go_was) begin fib_done = 1'b1; fib_data = 17'h1ABCD; end
    end else begin
      fib_done = 1'b0;
      if (r_cnt == 0) r_dly = rand_dly ? int'($urandom_range(1, 5)) : 3;
      if (!r_sent && !never_done) begin
        r_cnt++;
        if (r_cnt >= r_dly) begin fib_done = 1'b1; fib_data = rdata[fib_n]; r_sent = 1; end
      end
    end
    r_go_was = fib_go;
  end

  always @(posedge clk) begin
    #2;
    if (rand_ready) res_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: records requests, pops and pulses; checks operand/head stability.
  logic m_go_prev = 1'b0, m_hold = 1'b0;
  logic [4:0]  m_n_prev = '0;
  logic [21:0] m_head_prev = '0;
  always @(negedge clk) begin
    if (fib_go && !m_go_prev) req_q.push_back(fib_n);
    if (fib_go && m_go_prev) begin
      n_cmp++;
      if (fib_n !== m_n_prev) begin n_err++; $display("FAIL fib_n_stable got %0d want %0d", fib_n, m_n_prev); end
    end
    if (res_valid && m_hold) begin
      n_cmp++;
      if ({res_n, res_data} !== m_head_prev) begin
        n_err++; $display("FAIL head_stable got %h want %h", {res_n, res_data}, m_head_prev);
      end
    end
    if (fib_go) go_hi_cnt++;
    if (res_valid && res_ready) got_q.push_back({res_n, res_data});
    if (sweep_done) begin done_cnt++; busy_at_done = busy; end
    if (cfg_err) cfg_cnt++;
    m_go_prev = fib_go; m_n_prev = fib_n;
    m_hold = res_valid && !res_ready; m_head_prev = {res_n, res_data};
  end

  task automatic clear();
    req_q.delete(); got_q.delete();
    done_cnt = 0; cfg_cnt = 0; go_hi_cnt = 0; busy_at_done = 1'b1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #2 res_ready = v;
  endtask

  task automatic start_sweep(input int a, input int b);
    @(negedge clk); n_first = 5'(a); n_last = 5'(b); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == budget) begin n_cmp++; n_err++; $display("FAIL %s_timeout got busy=1 want busy=0", name); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; n_first = '0; n_last = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fib_go, busy, sweep_done, cfg_err, res_valid, timeout_err, fib_n} !== 11'b0) begin
      n_err++; $display("FAIL reset_state got %b want 0", {fib_go, busy, sweep_done, cfg_err, res_valid, timeout_err, fib_n});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear();
    start_sweep(2, 5);
    n_cmp++;
    if ({fib_go, busy, fib_n} !== {2'b11, 5'd2}) begin
      n_err++; $display("FAIL first_req got go=%b busy=%b n=%0d want 1 1 2", fib_go, busy, fib_n);
    end
    wait_idle(300, "basic");
    n_cmp++;
    if (req_q.size() != 4) begin n_err++; $display("FAIL basic_nreq got %0d want 4", req_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (req_q[i] !== 5'(2 + i)) begin n_err++; $display("FAIL basic_req%0d got %0d want %0d", i, req_q[i], 2 + i); end
      n_cmp++;
      if (got_q[i] !== {5'(2 + i), rdata[2 + i]}) begin
        n_err++; $display("FAIL basic_entry%0d got %h want %h", i, got_q[i], {5'(2 + i), rdata[2 + i]});
      end
    end
    n_cmp++;
    if (done_cnt != 1 || busy_at_done !== 1'b0) begin
      n_err++; $display("FAIL basic_done got cnt=%0d busy=%b want 1 0", done_cnt, busy_at_done);
    end
  endtask

  task automatic test_cfg_err();
    clear();
    start_sweep(7, 3);
    n_cmp++;
    if ({cfg_err, fib_go, busy} !== 3'b100) begin n_err++; $display("FAIL cfg_rev got %b want 100", {cfg_err, fib_go, busy}); end
    @(negedge clk);
    n_cmp++;
    if ({cfg_err, fib_go, busy} !== 3'b000) begin n_err++; $display("FAIL cfg_pulse got %b want 000", {cfg_err, fib_go, busy}); end
    start_sweep(0, 25);
    n_cmp++;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_max got %b want 1", cfg_err); end
    start_sweep(24, 24);
    wait_idle(100, "cfg_single");
    n_cmp++;
    if (req_q.size() != 1 || got_q.size() != 1 || got_q[0] !== {5'd24, 17'd124}) begin
      n_err++; $display("FAIL single24 got nreq=%0d nent=%0d e0=%h want 1 1 %h", req_q.size(), got_q.size(), got_q[0], {5'd24, 17'd124});
    end
    n_cmp++;
    if (cfg_cnt != 2) begin n_err++; $display("FAIL cfg_count got %0d want 2", cfg_cnt); end
  endtask

  task automatic test_stall();
    clear();
    set_ready(1'b0);
    start_sweep(0, 9);
    repeat (60) @(negedge clk);
    n_cmp++;
    if (req_q.size() != 4 || got_q.size() != 0 || {fib_go, busy, res_valid} !== 3'b011 || res_n !== 5'd0) begin
      n_err++; $display("FAIL stall got nreq=%0d nent=%0d go/busy/vld=%b head=%0d want 4 0 011 0", req_q.size(), got_q.size(), {fib_go, busy, res_valid}, res_n);
    end
    set_ready(1'b1);
    wait_idle(500, "stall");
    n_cmp++;
    if (got_q.size() != 10 || req_q.size() != 10 || done_cnt != 1) begin
      n_err++; $display("FAIL stall_total got nent=%0d nreq=%0d done=%0d want 10 10 1", got_q.size(), req_q.size(), done_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (got_q[i] !== {5'(i), rdata[i]}) begin n_err++; $display("FAIL stall_entry%0d got %h want %h", i, got_q[i], {5'(i), rdata[i]}); end
    end
  endtask

  task automatic test_reset_mid();
    int i;
    clear();
    start_sweep(0, 5);
    for (i = 0; i < 200; i++) begin
      if (req_q.size() == 3) break;
      @(negedge clk);
    end
    if (i == 200) begin n_cmp++; n_err++; $display("FAIL rmid_wait got nreq=%0d want 3", req_q.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({fib_go, res_valid, busy} !== 3'b000) begin n_err++; $display("FAIL rmid_abort got %b want 000", {fib_go, res_valid, busy}); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt != 0 || fib_go !== 1'b0) begin n_err++; $display("FAIL rmid_quiet got done=%0d go=%b want 0 0", done_cnt, fib_go); end
    clear();
    start_sweep(1, 3);
    wait_idle(200, "rmid_restart");
    n_cmp++;
    if (got_q.size() != 3 || done_cnt != 1) begin n_err++; $display("FAIL rmid_restart got nent=%0d done=%0d want 3 1", got_q.size(), done_cnt); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got_q[k] !== {5'(1 + k), rdata[1 + k]}) begin n_err++; $display("FAIL rmid_entry%0d got %h want %h", k, got_q[k], {5'(1 + k), rdata[1 + k]}); end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clear();
    gap_inject = 1;
    start_sweep(2, 5);
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) break;
      start = (k % 3 == 0); n_first = 5'd0; n_last = 5'd1;
    end
    start = 1'b0;
    if (k == 300) begin n_cmp++; n_err++; $display("FAIL b2b_timeout got busy=1 want busy=0"); end
    repeat (3) @(negedge clk);
    gap_inject = 0;
    n_cmp++;
    if (req_q.size() != 4 || got_q.size() != 4 || cfg_cnt != 0 || done_cnt != 1) begin
      n_err++; $display("FAIL b2b_counts got nreq=%0d nent=%0d cfg=%0d done=%0d want 4 4 0 1", req_q.size(), got_q.size(), cfg_cnt, done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_q[i] !== {5'(2 + i), rdata[2 + i]}) begin n_err++; $display("FAIL b2b_entry%0d got %h want %h", i, got_q[i], {5'(2 + i), rdata[2 + i]}); end
    end
  endtask

  task automatic test_random();
    int a, b, j;
    rand_ready = 1; rand_dly = 1;
    for (int it = 0; it < 8; it++) begin
      a = int'($urandom_range(0, 24));
      b = int'($urandom_range(a, 24));
      for (int n = 0; n < 32; n++) rdata[n] = 17'($urandom);
      clear();
      start_sweep(a, b);
      wait_idle(3000, "rand");
      for (j = 0; j < 300 && res_valid; j++) @(negedge clk);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (got_q.size() != b - a + 1 || done_cnt != 1) begin
        n_err++; $display("FAIL rand%0d_count got nent=%0d done=%0d want %0d 1", it, got_q.size(), done_cnt, b - a + 1);
      end
      for (int i = 0; i <= b - a; i++) begin
        n_cmp++;
        if (got_q[i] !== {5'(a + i), rdata[a + i]}) begin
          n_err++; $display("FAIL rand%0d_entry%0d got %h want %h", it, i, got_q[i], {5'(a + i), rdata[a + i]});
        end
      end
    end
    rand_ready = 0; rand_dly = 0;
    set_ready(1'b1);
    for (int n = 0; n < 32; n++) rdata[n] = 17'(100 + n);
  endtask

`ifdef FIB_TIMEOUT_EN
  task automatic test_timeout();
    clear();
    never_done = 1;
    start_sweep(3, 8);
    wait_idle(300, "tmo");
    n_cmp++;
    if (go_hi_cnt != 64 || timeout_err !== 1'b1 || busy !== 1'b0 || done_cnt != 0 || req_q.size() != 1) begin
      n_err++; $display("FAIL tmo got gocyc=%0d err=%b busy=%b done=%0d nreq=%0d want 64 1 0 0 1", go_hi_cnt, timeout_err, busy, done_cnt, req_q.size());
    end
    never_done = 0;
    clear();
    start_sweep(1, 1);
    n_cmp++;
    if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_clear got %b want 0", timeout_err); end
    wait_idle(100, "tmo_after");
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {5'd1, 17'd101}) begin
      n_err++; $display("FAIL tmo_after got nent=%0d e0=%h want 1 %h", got_q.size(), got_q[0], {5'd1, 17'd101});
    end
  endtask
`endif

  initial begin
    for (int n = 0; n < 32; n++) rdata[n] = 17'(100 + n);
    test_reset();
    test_basic();
    test_cfg_err();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef FIB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
